// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback logic for the MIPS pipeline.
// Holds the instruction leaving MEM, aligns and extends load data, and
// drives the register-file write port, the ID forwarding bus and a
// retired-instruction counter.
module mem_wb_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ms_to_ws_valid,
  output logic             ws_allow_in,
  input  logic [31:0]      ms_pc,
  input  logic             ms_gr_we,
  input  logic [4:0]       ms_dest,
  input  logic [31:0]      ms_alu_result,
  input  logic [31:0]      ms_mem_rdata,
  input  logic [2:0]       ms_load_op,
  input  logic             ws_stall,
  input  logic             ws_flush,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             ws_fwd_valid,
  output logic [4:0]       ws_fwd_dest,
  output logic [31:0]      ws_fwd_data,
  output logic [31:0]      debug_wb_pc,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_B    = 3'b001,
    LD_BU   = 3'b010,
    LD_H    = 3'b011,
    LD_HU   = 3'b100,
    LD_W    = 3'b101
  } load_op_e;

  logic        ws_valid;
  logic        ws_ready_go;
  logic        capture;
  logic        retire;
  logic        writes_gpr;

  logic [31:0] pc_r;
  logic        gr_we_r;
  logic [4:0]  dest_r;
  logic [31:0] alu_r;
  logic [31:0] rdata_r;
  logic [2:0]  load_op_r;
  logic [1:0]  off_r;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] wb_result;

  assign ws_ready_go = !ws_stall;
  assign ws_allow_in = !ws_valid || ws_ready_go;
  assign capture     = ms_to_ws_valid && ws_allow_in;
  assign retire      = ws_valid && ws_ready_go && !ws_flush;
  assign writes_gpr  = gr_we_r && (dest_r != 5'd0);

  // Valid bit: flush wins, otherwise follow MEM when WB can accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_valid <= 1'b0;
    end else if (ws_flush) begin
      ws_valid <= 1'b0;
    end else if (ws_allow_in) begin
      ws_valid <= ms_to_ws_valid;
    end
  end

  // Payload capture; fields latched under a flush are harmless because
  // ws_valid is cleared and every output is qualified by it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r      <= '0;
      gr_we_r   <= 1'b0;
      dest_r    <= '0;
      alu_r     <= '0;
      rdata_r   <= '0;
      load_op_r <= '0;
      off_r     <= '0;
    end else if (capture) begin
      pc_r      <= ms_pc;
      gr_we_r   <= ms_gr_we;
      dest_r    <= ms_dest;
      alu_r     <= ms_alu_result;
      rdata_r   <= ms_mem_rdata;
      load_op_r <= ms_load_op;
      off_r     <= ms_alu_result[1:0];
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // Select byte and halfword lanes by the captured address offset.
  always_comb begin
    byte_sel = rdata_r[7:0];
    case (off_r)
      2'd0: byte_sel = rdata_r[7:0];
      2'd1: byte_sel = rdata_r[15:8];
      2'd2: byte_sel = rdata_r[23:16];
      2'd3: byte_sel = rdata_r[31:24];
      default: byte_sel = rdata_r[7:0];
    endcase
    half_sel = off_r[1] ? rdata_r[31:16] : rdata_r[15:0];
  end

  // Extend the selected lane by load type; reserved encodings act as non-loads.
  always_comb begin
    wb_result = alu_r;
    case (load_op_r)
      LD_B:    wb_result = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   wb_result = {24'd0, byte_sel};
      LD_H:    wb_result = {{16{half_sel[15]}}, half_sel};
      LD_HU:   wb_result = {16'd0, half_sel};
      LD_W:    wb_result = rdata_r;
      default: wb_result = alu_r;
    endcase
  end

  // Register-file write port and forwarding bus.
  always_comb begin
    rf_we        = ws_valid && ws_ready_go && writes_gpr;
    rf_waddr     = dest_r;
    rf_wdata     = wb_result;
    ws_fwd_valid = ws_valid && writes_gpr;
    ws_fwd_dest  = dest_r;
    ws_fwd_data  = wb_result;
    debug_wb_pc  = ws_valid ? pc_r : '0;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ms_to_ws_valid;
  logic        ws_allow_in;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_alu_result;
  logic [31:0] ms_mem_rdata;
  logic [2:0]  ms_load_op;
  logic        ws_stall;
  logic        ws_flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_dest;
  logic [31:0] ws_fwd_data;
  logic [31:0] debug_wb_pc;
  logic [31:0] retire_cnt;

  // Narrow-counter instance for the wrap check.
  logic        rst4;
  logic        v4;
  logic        allow4;
  logic        rf_we4;
  logic [4:0]  waddr4;
  logic [31:0] wdata4;
  logic        fv4;
  logic [4:0]  fd4;
  logic [31:0] fdat4;
  logic [31:0] dpc4;
  logic [3:0]  cnt4;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rf_model [32];
  int          wcount   [32];

  always #5 clk = ~clk;

  mem_wb_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ms_to_ws_valid(ms_to_ws_valid), .ws_allow_in(ws_allow_in),
    .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_alu_result(ms_alu_result),
    .ms_mem_rdata(ms_mem_rdata), .ms_load_op(ms_load_op), .ws_stall(ws_stall),
    .ws_flush(ws_flush), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_fwd_valid(ws_fwd_valid), .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data),
    .debug_wb_pc(debug_wb_pc), .retire_cnt(retire_cnt)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .ms_to_ws_valid(v4), .ws_allow_in(allow4),
    .ms_pc(32'h0000_0400), .ms_gr_we(1'b0), .ms_dest(5'd0), .ms_alu_result(32'd0),
    .ms_mem_rdata(32'd0), .ms_load_op(3'd0), .ws_stall(1'b0),
    .ws_flush(1'b0), .rf_we(rf_we4), .rf_waddr(waddr4), .rf_wdata(wdata4),
    .ws_fwd_valid(fv4), .ws_fwd_dest(fd4), .ws_fwd_data(fdat4),
    .debug_wb_pc(dpc4), .retire_cnt(cnt4)
  );

  // Register file model: commits the write port on the clock edge.
  always @(posedge clk) begin
    if (rf_we) begin
      rf_model[rf_waddr] <= rf_wdata;
      wcount[rf_waddr]   <= wcount[rf_waddr] + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction for a single capture edge.
  task automatic issue(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic [2:0] op);
    ms_pc = pc; ms_gr_we = we; ms_dest = dest;
    ms_alu_result = alu; ms_mem_rdata = rdata; ms_load_op = op;
    ms_to_ws_valid = 1'b1;
    step();
    ms_to_ws_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_model[i] = '0;
      wcount[i]   = 0;
    end
    rst = 1'b1; rst4 = 1'b1; v4 = 1'b0;
    ws_stall = 1'b0; ws_flush = 1'b0;
    ms_to_ws_valid = 1'b1; ms_pc = 32'h0000_0100; ms_gr_we = 1'b1; ms_dest = 5'd5;
    ms_alu_result = 32'h55; ms_mem_rdata = 32'h0; ms_load_op = 3'd0;

    // Reset held with MEM offering an instruction.
    step(); step();
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    chk("rst_allow_in", {31'd0, ws_allow_in}, 32'd1);
    chk("rst_fwd_valid", {31'd0, ws_fwd_valid}, 32'd0);
    chk("rst_wb_pc", debug_wb_pc, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    rst = 1'b0; rst4 = 1'b0;
    step();
    ms_to_ws_valid = 1'b0;
    chk("first_wb_pc", debug_wb_pc, 32'h0000_0100);
    chk("first_rf_we", {31'd0, rf_we}, 32'd1);
    chk("first_wdata", rf_wdata, 32'h55);
    step();
    chk("first_cnt", retire_cnt, 32'd1);
    chk("first_r5", rf_model[5], 32'h55);
    chk("idle_wb_pc", debug_wb_pc, 32'd0);

    // Load alignment and extension.
    issue(32'h104, 1'b1, 5'd3, 32'h1003, 32'h80FF1234, 3'b001);
    chk("lb", rf_wdata, 32'hFFFFFF80);
    issue(32'h108, 1'b1, 5'd3, 32'h1003, 32'h80FF1234, 3'b010);
    chk("lbu", rf_wdata, 32'h00000080);
    issue(32'h10C, 1'b1, 5'd3, 32'h1002, 32'h80FF1234, 3'b011);
    chk("lh_off2", rf_wdata, 32'hFFFF80FF);
    issue(32'h110, 1'b1, 5'd3, 32'h1000, 32'h80FF1234, 3'b100);
    chk("lhu_off0", rf_wdata, 32'h00001234);
    issue(32'h114, 1'b1, 5'd3, 32'h1000, 32'h80FF1234, 3'b101);
    chk("lw", rf_wdata, 32'h80FF1234);
    issue(32'h118, 1'b1, 5'd3, 32'h1001, 32'h80FF1234, 3'b001);
    chk("lb_off1", rf_wdata, 32'h00000012);
    issue(32'h11C, 1'b1, 5'd3, 32'h1002, 32'h80FF1234, 3'b110);
    chk("op110_alu", rf_wdata, 32'h00001002);
    step();
    chk("load_cnt", retire_cnt, 32'd8);

    // ALU write to r2, then the same with dest 0.
    issue(32'h120, 1'b1, 5'd2, 32'h0000000C, 32'h0, 3'b000);
    chk("alu_rf_we", {31'd0, rf_we}, 32'd1);
    chk("alu_waddr", {27'd0, rf_waddr}, 32'd2);
    chk("alu_fwd_data", ws_fwd_data, 32'h0000000C);
    step();
    chk("alu_we_once", {31'd0, rf_we}, 32'd0);
    chk("alu_r2", rf_model[2], 32'h0000000C);
    issue(32'h124, 1'b1, 5'd0, 32'h0000000C, 32'h0, 3'b000);
    chk("r0_rf_we", {31'd0, rf_we}, 32'd0);
    chk("r0_fwd_valid", {31'd0, ws_fwd_valid}, 32'd0);
    step();
    chk("alu_cnt", retire_cnt, 32'd10);

    // Back-to-back stream, same destination twice.
    issue(32'h130, 1'b1, 5'd9, 32'd1, 32'h0, 3'b000);
    chk("b2b_we0", {31'd0, rf_we}, 32'd1);
    issue(32'h134, 1'b1, 5'd9, 32'd2, 32'h0, 3'b000);
    chk("b2b_we1", {31'd0, rf_we}, 32'd1);
    issue(32'h138, 1'b1, 5'd13, 32'd3, 32'h0, 3'b000);
    chk("b2b_we2", {31'd0, rf_we}, 32'd1);
    step();
    chk("b2b_r9", rf_model[9], 32'd2);
    chk("b2b_r13", rf_model[13], 32'd3);
    chk("b2b_cnt", retire_cnt, 32'd13);

    // Stall with a resident writer while MEM offers the next instruction.
    issue(32'h200, 1'b1, 5'd7, 32'h77, 32'h0, 3'b000);
    ws_stall = 1'b1;
    ms_pc = 32'h204; ms_gr_we = 1'b1; ms_dest = 5'd8; ms_alu_result = 32'h88; ms_load_op = 3'd0;
    ms_to_ws_valid = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk("stall_allow_in", {31'd0, ws_allow_in}, 32'd0);
      chk("stall_rf_we", {31'd0, rf_we}, 32'd0);
      chk("stall_fwd_valid", {31'd0, ws_fwd_valid}, 32'd1);
      chk("stall_wb_pc", debug_wb_pc, 32'h200);
      step();
    end
    chk("stall_cnt", retire_cnt, 32'd13);
    ws_stall = 1'b0;
    #1;
    chk("release_rf_we", {31'd0, rf_we}, 32'd1);
    chk("release_waddr", {27'd0, rf_waddr}, 32'd7);
    step();
    ms_to_ws_valid = 1'b0;
    chk("release_next_pc", debug_wb_pc, 32'h204);
    chk("release_cnt", retire_cnt, 32'd14);
    chk("release_r7", rf_model[7], 32'h77);
    chk("release_r7_writes", wcount[7], 32'd1);
    step();
    chk("held_r8", rf_model[8], 32'h88);
    chk("held_cnt", retire_cnt, 32'd15);

    // Flush coinciding with a capture.
    ms_pc = 32'h300; ms_gr_we = 1'b1; ms_dest = 5'd10; ms_alu_result = 32'hAA; ms_load_op = 3'd0;
    ms_to_ws_valid = 1'b1; ws_flush = 1'b1;
    step();
    ms_to_ws_valid = 1'b0; ws_flush = 1'b0;
    chk("flush_wb_pc", debug_wb_pc, 32'd0);
    chk("flush_rf_we", {31'd0, rf_we}, 32'd0);
    chk("flush_fwd_valid", {31'd0, ws_fwd_valid}, 32'd0);
    step();
    chk("flush_cnt", retire_cnt, 32'd15);
    chk("flush_r10_writes", wcount[10], 32'd0);

    // Asynchronous reset between edges.
    issue(32'h400, 1'b1, 5'd11, 32'hBB, 32'h0, 3'b000);
    chk("pre_rst_rf_we", {31'd0, rf_we}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rf_we", {31'd0, rf_we}, 32'd0);
    chk("async_wb_pc", debug_wb_pc, 32'd0);
    chk("async_cnt", retire_cnt, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("async_r11_writes", wcount[11], 32'd0);

    // Narrow counter: 15 retirements reach all-ones, the next wraps to 0.
    v4 = 1'b1;
    for (int c = 0; c < 15; c++) step();
    v4 = 1'b0;
    step();
    chk("cnt4_full", {28'd0, cnt4}, 32'h0000000F);
    v4 = 1'b1;
    step();
    v4 = 1'b0;
    step();
    chk("cnt4_wrap", {28'd0, cnt4}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
